// File: rtl/playback_sequencer_pkg.sv
// Shared types for the playback sequencer: LED colour codes, FSM states and the LED decoder.
// The FLASH states exist only when PLAYBACK_FLASH_EN is defined.
package playback_sequencer_pkg;

  localparam int LED_COUNT = 4;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    RED    = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } color_t;

`ifdef PLAYBACK_FLASH_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_WAIT, ST_ON, ST_GAP, ST_DONE, ST_FLASH_ON, ST_FLASH_OFF
  } playback_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_WAIT, ST_ON, ST_GAP, ST_DONE
  } playback_state_t;
`endif

  // One-hot LED vector, bit index equals the colour code.
  function automatic logic [LED_COUNT-1:0] led_decode(input color_t c);
    return (LED_COUNT)'(1) << c;
  endfunction

endpackage

// File: rtl/playback_sequencer_if.sv
// Sequence memory read port shared between the sequencer (master) and the memory (slave).
interface playback_sequencer_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 2
);
  logic                  mem_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;

  modport master (output mem_rd, output mem_addr, input mem_data);
  modport slave  (input mem_rd, input mem_addr, output mem_data);
endinterface

// File: rtl/playback_sequencer_phase_timer.sv
// Loadable down-counter; zero flags the last cycle of a phase, so loading T-1 gives a T-cycle phase.
module phase_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);
  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)                count <= '0;
    else if (load)          count <= load_value;
    else if (count != '0)   count <= count - 1'b1;
  end

  assign zero = (count == '0);
endmodule

// File: rtl/playback_sequencer.sv
// Replays the stored colour sequence on four LEDs with speed-dependent on/gap timing.
// Optional all-LED flash mode is compiled in with `define PLAYBACK_FLASH_EN.
module playback_sequencer
  import playback_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 2,
  parameter int T_ON_FAST  = 4,
  parameter int T_GAP_FAST = 2,
  parameter int T_ON_SLOW  = 8,
  parameter int T_GAP_SLOW = 4
`ifdef PLAYBACK_FLASH_EN
  , parameter int FLASH_COUNT = 3
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  speed,
  input  logic [ADDR_WIDTH-1:0] last_index,
`ifdef PLAYBACK_FLASH_EN
  input  logic                  flash_req,
`endif
  playback_sequencer_if.master  mem,
  output logic                  led_green,
  output logic                  led_red,
  output logic                  led_blue,
  output logic                  led_yellow,
  output logic                  busy,
  output logic                  done
);

  localparam int T_MAX_ON  = (T_ON_FAST > T_ON_SLOW) ? T_ON_FAST : T_ON_SLOW;
  localparam int T_MAX_GAP = (T_GAP_FAST > T_GAP_SLOW) ? T_GAP_FAST : T_GAP_SLOW;
  localparam int T_MAX     = (T_MAX_ON > T_MAX_GAP) ? T_MAX_ON : T_MAX_GAP;
  localparam int TW        = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  function automatic logic [TW-1:0] on_len_m1(input logic fast);
    return fast ? TW'(T_ON_FAST - 1) : TW'(T_ON_SLOW - 1);
  endfunction

  function automatic logic [TW-1:0] gap_len_m1(input logic fast);
    return fast ? TW'(T_GAP_FAST - 1) : TW'(T_GAP_SLOW - 1);
  endfunction

  playback_state_t       state, state_nx;
  logic [ADDR_WIDTH-1:0] idx, idx_nx, last_q;
  logic                  speed_q, speed_load, last_load;
  logic                  t_load, t_zero;
  logic [TW-1:0]         t_value;
  logic [DATA_WIDTH-1:0] rd_data;
  color_t                color_q;
  logic [LED_COUNT-1:0]  leds;
`ifdef PLAYBACK_FLASH_EN
  localparam int FCW = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT) : 1;
  logic [FCW-1:0] flash_cnt, flash_cnt_nx;
`endif

  phase_timer #(.WIDTH(TW)) u_phase_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (t_load),
    .load_value (t_value),
    .zero       (t_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      speed_q <= 1'b0;
      last_q  <= '0;
`ifdef PLAYBACK_FLASH_EN
      flash_cnt <= '0;
`endif
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (speed_load) speed_q <= speed;
      if (last_load)  last_q  <= last_index;
`ifdef PLAYBACK_FLASH_EN
      flash_cnt <= flash_cnt_nx;
`endif
    end
  end

  // Colour is a data register: captured from the read data one cycle after the strobe.
  assign rd_data = mem.mem_data;
  always_ff @(posedge clk) begin
    if (state == ST_WAIT) color_q <= color_t'(rd_data[1:0]);
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    speed_load = 1'b0;
    last_load  = 1'b0;
    t_load     = 1'b0;
    t_value    = '0;
`ifdef PLAYBACK_FLASH_EN
    flash_cnt_nx = flash_cnt;
`endif
    if (abort) begin
      state_nx = ST_IDLE;
      idx_nx   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_nx   = ST_FETCH;
            idx_nx     = '0;
            speed_load = 1'b1;
            last_load  = 1'b1;
          end
`ifdef PLAYBACK_FLASH_EN
          else if (flash_req) begin
            state_nx     = ST_FLASH_ON;
            speed_load   = 1'b1;
            t_load       = 1'b1;
            t_value      = on_len_m1(speed);
            flash_cnt_nx = '0;
          end
`endif
        end
        ST_FETCH: state_nx = ST_WAIT;
        ST_WAIT: begin
          state_nx = ST_ON;
          t_load   = 1'b1;
          t_value  = on_len_m1(speed_q);
        end
        ST_ON: begin
          if (t_zero) begin
            state_nx = ST_GAP;
            t_load   = 1'b1;
            t_value  = gap_len_m1(speed_q);
          end
        end
        // idx is compared before incrementing so a full-depth sequence never wraps.
        ST_GAP: begin
          if (t_zero) begin
            if (idx == last_q) begin
              state_nx = ST_DONE;
            end else begin
              idx_nx   = idx + 1'b1;
              state_nx = ST_FETCH;
            end
          end
        end
        ST_DONE: state_nx = ST_IDLE;
`ifdef PLAYBACK_FLASH_EN
        ST_FLASH_ON: begin
          if (t_zero) begin
            state_nx = ST_FLASH_OFF;
            t_load   = 1'b1;
            t_value  = gap_len_m1(speed_q);
          end
        end
        ST_FLASH_OFF: begin
          if (t_zero) begin
            if (flash_cnt == FCW'(FLASH_COUNT - 1)) begin
              state_nx = ST_DONE;
            end else begin
              flash_cnt_nx = flash_cnt + 1'b1;
              state_nx     = ST_FLASH_ON;
              t_load       = 1'b1;
              t_value      = on_len_m1(speed_q);
            end
          end
        end
`endif
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    leds = '0;
    if (state == ST_ON) leds = led_decode(color_q);
`ifdef PLAYBACK_FLASH_EN
    if (state == ST_FLASH_ON) leds = '1;
`endif
  end

  assign {led_yellow, led_blue, led_red, led_green} = leds;
  assign busy         = (state != ST_IDLE) && (state != ST_DONE);
  assign done         = (state == ST_DONE);
  assign mem.mem_rd   = (state == ST_FETCH);
  assign mem.mem_addr = idx;

endmodule

// File: tb/tb_playback_sequencer.sv
// Scoreboard bench for playback_sequencer: per-cycle expected traces from a timeline model, checked by a monitor.
module tb_playback_sequencer;
  localparam int AW = 5;
  localparam int DW = 2;
  localparam int TOF = 4;
  localparam int TGF = 2;
  localparam int TOS = 8;
  localparam int TGS = 4;
  localparam int FC = 2;

  typedef struct packed {
    logic          rd;
    logic [AW-1:0] addr;
    logic [3:0]    leds;
    logic          busy;
    logic          done;
  } obs_t;

  typedef struct {
    string name;
    int    cyc;
    obs_t  v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic speed = 1'b0;
  logic [AW-1:0] last_index = '0;
`ifdef PLAYBACK_FLASH_EN
  logic flash_req = 1'b0;
`endif
  logic led_green, led_red, led_blue, led_yellow, busy, done;

  logic [1:0] mem [0:31];
  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  playback_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  playback_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .T_ON_FAST(TOF), .T_GAP_FAST(TGF), .T_ON_SLOW(TOS), .T_GAP_SLOW(TGS)
`ifdef PLAYBACK_FLASH_EN
    , .FLASH_COUNT(FC)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .speed(speed),
    .last_index(last_index),
`ifdef PLAYBACK_FLASH_EN
    .flash_req(flash_req),
`endif
    .mem(bus),
    .led_green(led_green), .led_red(led_red), .led_blue(led_blue), .led_yellow(led_yellow),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory model: data valid one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
  end

  function automatic obs_t observe();
    obs_t o;
    o.rd   = bus.mem_rd;
    o.addr = bus.mem_rd ? bus.mem_addr : '0;
    o.leds = {led_yellow, led_blue, led_red, led_green};
    o.busy = busy;
    o.done = done;
    return o;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endfunction

  // Monitor: one expected observation per cycle while a trace is queued.
  initial begin
    exp_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = observe();
        n_cmp++;
        if (a !== e.v) begin
          n_err++;
          $display("FAIL %s cycle %0d: got rd=%0d addr=%0d leds=%b busy=%0d done=%0d, expected rd=%0d addr=%0d leds=%b busy=%0d done=%0d",
                   e.name, e.cyc, a.rd, a.addr, a.leds, a.busy, a.done,
                   e.v.rd, e.v.addr, e.v.leds, e.v.busy, e.v.done);
        end
      end
    end
  end

  // Timeline model: item k occupies cycles 1+k*per .. (k+1)*per; read first, LED from offset 2.
  task automatic build_play(input string name, input int n, input bit fast, input int abort_at, input int ncyc);
    int ton, tgap, per, k, off;
    exp_t e;
    ton  = fast ? TOF : TOS;
    tgap = fast ? TGF : TGS;
    per  = 2 + ton + tgap;
    for (int c = 0; c < ncyc; c++) begin
      e.name = name;
      e.cyc  = c;
      e.v    = '0;
      if (abort_at < 0 || c <= abort_at) begin
        if (c >= 1 && c <= n * per) begin
          k = (c - 1) / per;
          off = (c - 1) % per;
          e.v.busy = 1'b1;
          if (off == 0) begin
            e.v.rd   = 1'b1;
            e.v.addr = k[AW-1:0];
          end
          if (off >= 2 && off < 2 + ton) e.v.leds = 4'b0001 << mem[k];
        end else if (c == n * per + 1) begin
          e.v.done = 1'b1;
        end
      end
      exp_q.push_back(e);
    end
  endtask

`ifdef PLAYBACK_FLASH_EN
  task automatic build_flash(input string name, input bit fast, input int ncyc);
    int ton, tgap, per;
    exp_t e;
    ton  = fast ? TOF : TOS;
    tgap = fast ? TGF : TGS;
    per  = ton + tgap;
    for (int c = 0; c < ncyc; c++) begin
      e.name = name;
      e.cyc  = c;
      e.v    = '0;
      if (c >= 1 && c <= FC * per) begin
        e.v.busy = 1'b1;
        if ((c - 1) % per < ton) e.v.leds = 4'b1111;
      end else if (c == FC * per + 1) begin
        e.v.done = 1'b1;
      end
      exp_q.push_back(e);
    end
  endtask
`endif

  // Cycle 0 is the cycle in which start is presented.
  task automatic drive(input int ncyc, input bit go, input int abort_at, input int rst_at, input int restart_at);
    int w;
    for (int c = 0; c < ncyc; c++) begin
      start = (go && c == 0) || (c == restart_at);
      abort = (c == abort_at);
      rst   = (c == rst_at);
`ifdef PLAYBACK_FLASH_EN
      if (c == 1) flash_req = 1'b0;
`endif
      if (c == restart_at) begin
        speed      = ~speed;
        last_index = '0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    w = 0;
    while (exp_q.size() > 0 && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL trace_drain: %0d observations left, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, per, ab;
    bit fast;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'(observe()), 32'd0);
    check("reset_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    mem[0] = 2'd0; mem[1] = 2'd1; mem[2] = 2'd2; mem[3] = 2'd3;
    speed = 1'b1; last_index = 5'd3;
    build_play("s1_four_fast", 4, 1'b1, -1, 36);
    drive(36, 1'b1, -1, -1, -1);

    mem[0] = 2'd1;
    speed = 1'b0; last_index = 5'd0;
    build_play("s2_one_slow", 1, 1'b0, -1, 18);
    drive(18, 1'b1, -1, -1, -1);

    mem[0] = 2'd0; mem[1] = 2'd1; mem[2] = 2'd2; mem[3] = 2'd3;
    speed = 1'b1; last_index = 5'd3;
    build_play("s3_abort5", 4, 1'b1, 5, 12);
    drive(12, 1'b1, 5, -1, -1);
    check("s3_idx_cleared", 32'(bus.mem_addr), 32'd0);

    speed = 1'b1; last_index = 5'd3;
    build_play("s4_restart_ignored", 4, 1'b1, -1, 36);
    drive(36, 1'b1, -1, -1, 10);

    speed = 1'b1; last_index = 5'd3;
    build_play("s4_start_abort_idle", 4, 1'b1, 0, 6);
    drive(6, 1'b1, 0, -1, -1);

    for (int i = 0; i < 32; i++) mem[i] = 2'd3;
    speed = 1'b1; last_index = 5'd31;
    build_play("s5_full_depth", 32, 1'b1, -1, 260);
    drive(260, 1'b1, -1, -1, -1);

    mem[0] = 2'd2; mem[1] = 2'd0;
    speed = 1'b1; last_index = 5'd1;
    build_play("s6_rst_mid", 2, 1'b1, 5, 12);
    drive(12, 1'b1, -1, 5, -1);
    check("s6_idx_cleared", 32'(bus.mem_addr), 32'd0);

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 8);
      fast = 1'($urandom_range(0, 1));
      per = fast ? (2 + TOF + TGF) : (2 + TOS + TGS);
      for (int i = 0; i < 32; i++) mem[i] = 2'($urandom_range(0, 3));
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n * per) : -1;
      speed = fast;
      last_index = AW'(n - 1);
      build_play($sformatf("rand%0d", r), n, fast, ab, n * per + 4);
      drive(n * per + 4, 1'b1, ab, -1, -1);
    end

`ifdef PLAYBACK_FLASH_EN
    speed = 1'b1;
    flash_req = 1'b1;
    build_flash("s7_flash_fast", 1'b1, 16);
    drive(16, 1'b0, -1, -1, -1);

    speed = 1'b0;
    flash_req = 1'b1;
    build_flash("s7_flash_slow", 1'b0, 28);
    drive(28, 1'b0, -1, -1, -1);

    mem[0] = 2'd3;
    speed = 1'b1; last_index = 5'd0;
    flash_req = 1'b1;
    build_play("s7_start_beats_flash", 1, 1'b1, -1, 12);
    drive(12, 1'b1, -1, -1, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
